// File: rtl/fb_pkg.sv
// Shared types and default geometry for the double-buffered frame buffer.
package fb_pkg;

  localparam int unsigned FB_ROW_BITS = 6;
  localparam int unsigned FB_COL_BITS = 7;
  localparam int unsigned FB_PIX_W    = 12;
  localparam int unsigned FB_CNT_W    = 8;
  localparam int unsigned FB_ADDR_W   = FB_ROW_BITS + FB_COL_BITS + 1;

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    WAIT_SWAP = 2'd1,
    SWAP      = 2'd2
  } fb_state_e;

endpackage

// File: rtl/frame_buffer_ctrl_if.sv
// Tracer write port, scanout read port and bank status of the frame buffer.
interface frame_buffer_ctrl_if
  import fb_pkg::*;
#(
  parameter int unsigned ROW_BITS = FB_ROW_BITS,
  parameter int unsigned COL_BITS = FB_COL_BITS,
  parameter int unsigned PIX_W    = FB_PIX_W,
  parameter int unsigned CNT_W    = FB_CNT_W
) ();

  logic                wr_en;
  logic [ROW_BITS-1:0] wr_row;
  logic [COL_BITS-1:0] wr_col;
  logic [PIX_W-1:0]    wr_data;
  logic                wr_last;
  logic                wr_ready;
  logic [ROW_BITS-1:0] rd_row;
  logic [COL_BITS-1:0] rd_col;
  logic [PIX_W-1:0]    rd_data;
  logic                vblank;
  logic                front_sel;
  logic                swap_pulse;
  logic [CNT_W-1:0]    frame_cnt;

  modport master (
    output wr_en, wr_row, wr_col, wr_data, wr_last, rd_row, rd_col, vblank,
    input  wr_ready, rd_data, front_sel, swap_pulse, frame_cnt
  );

  modport slave (
    input  wr_en, wr_row, wr_col, wr_data, wr_last, rd_row, rd_col, vblank,
    output wr_ready, rd_data, front_sel, swap_pulse, frame_cnt
  );

endinterface

// File: rtl/dual_port_ram.sv
// Simple dual-port RAM: one synchronous write port, one asynchronous read port.
module dual_port_ram #(
  parameter int unsigned WIDTH  = 14,
  parameter int unsigned LENGTH = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [WIDTH-1:0]  waddr,
  input  logic [LENGTH-1:0] wdata,
  input  logic [WIDTH-1:0]  raddr,
  output logic [LENGTH-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << WIDTH;

  logic [LENGTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/frame_buffer_ctrl.sv
// Double-buffered pixel frame buffer: tracer fills the back bank, scanout reads the front.
// Define FB_TEAR_FREE_EN to defer bank swaps to the next vblank rising edge.
module frame_buffer_ctrl
  import fb_pkg::*;
#(
  parameter int unsigned ROW_BITS = FB_ROW_BITS,
  parameter int unsigned COL_BITS = FB_COL_BITS,
  parameter int unsigned PIX_W    = FB_PIX_W,
  parameter int unsigned CNT_W    = FB_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  frame_buffer_ctrl_if.slave bus
);

  localparam int unsigned ADDR_W = ROW_BITS + COL_BITS + 1;

  fb_state_e         state_q, state_d;
  logic              front_sel_q, front_sel_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic              wr_ready_q, wr_ready_d;
  logic              swap_pulse_q, swap_pulse_d;
  logic [PIX_W-1:0]  rd_data_q, rd_data_d;

  logic              wr_accept_c;
  logic [ADDR_W-1:0] waddr_c;
  logic [ADDR_W-1:0] raddr_c;
  logic [PIX_W-1:0]  ram_rdata;

`ifdef FB_TEAR_FREE_EN
  logic vblank_q, vblank_d;
  logic vblank_rise_c;
`endif

  // Back bank is always the one not on display.
  assign waddr_c = {~front_sel_q, bus.wr_col, bus.wr_row};
  assign raddr_c = { front_sel_q, bus.rd_col, bus.rd_row};

  dual_port_ram #(
    .WIDTH  (ADDR_W),
    .LENGTH (PIX_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_accept_c),
    .waddr (waddr_c),
    .wdata (bus.wr_data),
    .raddr (raddr_c),
    .rdata (ram_rdata)
  );

  // Next-state, bank toggle, frame count and registered outputs.
  always_comb begin
    state_d     = state_q;
    front_sel_d = front_sel_q;
    frame_cnt_d = frame_cnt_q;
    wr_accept_c = bus.wr_en & wr_ready_q;
    rd_data_d   = ram_rdata;
`ifdef FB_TEAR_FREE_EN
    vblank_d      = bus.vblank;
    vblank_rise_c = bus.vblank & ~vblank_q;
`endif

    case (state_q)
      FILL: begin
        if (wr_accept_c && bus.wr_last) begin
`ifdef FB_TEAR_FREE_EN
          state_d = WAIT_SWAP;
`else
          state_d = SWAP;
`endif
        end
      end
      WAIT_SWAP: begin
`ifdef FB_TEAR_FREE_EN
        if (vblank_rise_c) begin
          state_d = SWAP;
        end
`else
        state_d = FILL;
`endif
      end
      SWAP:    state_d = FILL;
      default: state_d = FILL;
    endcase

    // SWAP always exits to FILL, so state_d == SWAP marks the entry edge.
    if (state_d == SWAP) begin
      front_sel_d = ~front_sel_q;
      frame_cnt_d = frame_cnt_q + CNT_W'(1);
    end

    wr_ready_d   = (state_d == FILL);
    swap_pulse_d = (state_d == SWAP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      front_sel_q  <= 1'b0;
      frame_cnt_q  <= '0;
      wr_ready_q   <= 1'b1;
      swap_pulse_q <= 1'b0;
      rd_data_q    <= '0;
`ifdef FB_TEAR_FREE_EN
      vblank_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      front_sel_q  <= front_sel_d;
      frame_cnt_q  <= frame_cnt_d;
      wr_ready_q   <= wr_ready_d;
      swap_pulse_q <= swap_pulse_d;
      rd_data_q    <= rd_data_d;
`ifdef FB_TEAR_FREE_EN
      vblank_q     <= vblank_d;
`endif
    end
  end

  assign bus.wr_ready   = wr_ready_q;
  assign bus.swap_pulse = swap_pulse_q;
  assign bus.front_sel  = front_sel_q;
  assign bus.frame_cnt  = frame_cnt_q;
  assign bus.rd_data    = rd_data_q;

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Directed bench for frame_buffer_ctrl; scenarios follow whether FB_TEAR_FREE_EN is defined.
module tb_frame_buffer_ctrl;

  localparam int unsigned ROW_BITS = 6;
  localparam int unsigned COL_BITS = 7;
  localparam int unsigned PIX_W    = 12;
  localparam int unsigned CNT_W    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  frame_buffer_ctrl_if #(
    .ROW_BITS (ROW_BITS), .COL_BITS (COL_BITS), .PIX_W (PIX_W), .CNT_W (CNT_W)
  ) bus ();

  frame_buffer_ctrl #(
    .ROW_BITS (ROW_BITS), .COL_BITS (COL_BITS), .PIX_W (PIX_W), .CNT_W (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one pixel for exactly one edge, then idle the write port.
  task automatic drive_px(input int r, input int c, input int pix, input bit last);
    bus.wr_en   = 1'b1;
    bus.wr_row  = ROW_BITS'(r);
    bus.wr_col  = COL_BITS'(c);
    bus.wr_data = PIX_W'(pix);
    bus.wr_last = last;
    step();
    bus.wr_en   = 1'b0;
    bus.wr_last = 1'b0;
  endtask

  task automatic set_rd(input int r, input int c);
    bus.rd_row = ROW_BITS'(r);
    bus.rd_col = COL_BITS'(c);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++; if (bus.front_sel !== 1'b0) begin bad++; $display("FAIL reset_front got=%0h exp=0", bus.front_sel); end
    total++; if (bus.frame_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0h exp=0", bus.frame_cnt); end
    total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0h exp=1", bus.wr_ready); end
    total++; if (bus.swap_pulse !== 1'b0) begin bad++; $display("FAIL reset_swap got=%0h exp=0", bus.swap_pulse); end
    total++; if (bus.rd_data !== 12'h000) begin bad++; $display("FAIL reset_rd_data got=%0h exp=0", bus.rd_data); end
    rst = 1'b0;
  endtask

`ifdef FB_TEAR_FREE_EN

  task automatic pulse_vblank();
    bus.vblank = 1'b1;
    step();
    bus.vblank = 1'b0;
    step();
  endtask

  task automatic test_handoff();
    drive_px(3, 5, 'hABC, 1'b1);
    total++; if (bus.wr_ready !== 1'b0) begin bad++; $display("FAIL handoff_wait_ready got=%0h exp=0", bus.wr_ready); end
    step();
    step();
    total++; if (bus.front_sel !== 1'b0) begin bad++; $display("FAIL handoff_wait_front got=%0h exp=0", bus.front_sel); end
    bus.vblank = 1'b1;
    step();
    total++; if (bus.swap_pulse !== 1'b1) begin bad++; $display("FAIL handoff_swap got=%0h exp=1", bus.swap_pulse); end
    total++; if (bus.front_sel !== 1'b1) begin bad++; $display("FAIL handoff_front got=%0h exp=1", bus.front_sel); end
    total++; if (bus.frame_cnt !== 8'd1) begin bad++; $display("FAIL handoff_cnt got=%0h exp=1", bus.frame_cnt); end
    bus.vblank = 1'b0;
    step();
    total++; if (bus.swap_pulse !== 1'b0) begin bad++; $display("FAIL handoff_swap_end got=%0h exp=0", bus.swap_pulse); end
    total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL handoff_ready got=%0h exp=1", bus.wr_ready); end
    set_rd(3, 5);
    step();
    total++; if (bus.rd_data !== 12'hABC) begin bad++; $display("FAIL handoff_read got=%0h exp=abc", bus.rd_data); end
  endtask

  task automatic test_stall();
    int ready_errs;
    ready_errs = 0;
    drive_px(0, 0, 'h001, 1'b1);
    bus.wr_en   = 1'b1;
    bus.wr_row  = ROW_BITS'(3);
    bus.wr_col  = COL_BITS'(5);
    bus.wr_data = PIX_W'('h123);
    bus.wr_last = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (bus.wr_ready !== 1'b0) ready_errs++;
      step();
    end
    bus.wr_en   = 1'b0;
    bus.wr_last = 1'b0;
    total++; if (ready_errs !== 0) begin bad++; $display("FAIL stall_ready got=%0d_cycles_high exp=0", ready_errs); end
    total++; if (bus.frame_cnt !== 8'd1) begin bad++; $display("FAIL stall_no_swap got=%0h exp=1", bus.frame_cnt); end
    pulse_vblank();
    total++; if (bus.front_sel !== 1'b0) begin bad++; $display("FAIL stall_front got=%0h exp=0", bus.front_sel); end
    drive_px(0, 1, 'h002, 1'b1);
    pulse_vblank();
    total++; if (bus.frame_cnt !== 8'd3) begin bad++; $display("FAIL stall_cnt got=%0h exp=3", bus.frame_cnt); end
    set_rd(3, 5);
    step();
    total++; if (bus.rd_data !== 12'hABC) begin bad++; $display("FAIL stall_read got=%0h exp=abc", bus.rd_data); end
  endtask

  task automatic test_coincident();
    int early;
    early = 0;
    bus.vblank = 1'b1;
    drive_px(1, 1, 'h055, 1'b1);
    for (int i = 0; i < 5; i++) begin
      if (bus.swap_pulse !== 1'b0) early++;
      step();
    end
    total++; if (early !== 0) begin bad++; $display("FAIL coincident_early got=%0d exp=0", early); end
    total++; if (bus.frame_cnt !== 8'd3) begin bad++; $display("FAIL coincident_cnt got=%0h exp=3", bus.frame_cnt); end
    bus.vblank = 1'b0;
    step();
    bus.vblank = 1'b1;
    step();
    total++; if (bus.swap_pulse !== 1'b1) begin bad++; $display("FAIL coincident_swap got=%0h exp=1", bus.swap_pulse); end
    total++; if (bus.front_sel !== 1'b0) begin bad++; $display("FAIL coincident_front got=%0h exp=0", bus.front_sel); end
    bus.vblank = 1'b0;
    step();
  endtask

  task automatic test_reset_abandon();
    drive_px(2, 2, 'h0F0, 1'b1);
    do_reset();
    pulse_vblank();
    total++; if (bus.frame_cnt !== 8'd0) begin bad++; $display("FAIL abandon_cnt got=%0h exp=0", bus.frame_cnt); end
    total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL abandon_ready got=%0h exp=1", bus.wr_ready); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 256; i++) begin
      drive_px(0, 2, i, 1'b1);
      pulse_vblank();
      if (i == 254) begin
        total++; if (bus.frame_cnt !== 8'd255) begin bad++; $display("FAIL wrap_255 got=%0h exp=ff", bus.frame_cnt); end
      end
    end
    total++; if (bus.frame_cnt !== 8'd0) begin bad++; $display("FAIL wrap_cnt got=%0h exp=0", bus.frame_cnt); end
    total++; if (bus.front_sel !== 1'b0) begin bad++; $display("FAIL wrap_front got=%0h exp=0", bus.front_sel); end
  endtask

`else

  task automatic test_handoff();
    drive_px(3, 5, 'hABC, 1'b1);
    total++; if (bus.swap_pulse !== 1'b1) begin bad++; $display("FAIL handoff_swap got=%0h exp=1", bus.swap_pulse); end
    total++; if (bus.wr_ready !== 1'b0) begin bad++; $display("FAIL handoff_swap_ready got=%0h exp=0", bus.wr_ready); end
    total++; if (bus.front_sel !== 1'b1) begin bad++; $display("FAIL handoff_front got=%0h exp=1", bus.front_sel); end
    total++; if (bus.frame_cnt !== 8'd1) begin bad++; $display("FAIL handoff_cnt got=%0h exp=1", bus.frame_cnt); end
    step();
    total++; if (bus.swap_pulse !== 1'b0) begin bad++; $display("FAIL handoff_swap_end got=%0h exp=0", bus.swap_pulse); end
    total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL handoff_ready got=%0h exp=1", bus.wr_ready); end
    set_rd(3, 5);
    step();
    total++; if (bus.rd_data !== 12'hABC) begin bad++; $display("FAIL handoff_read got=%0h exp=abc", bus.rd_data); end
  endtask

  task automatic test_swap_ignores_writes();
    drive_px(3, 5, 'h123, 1'b0);
    drive_px(0, 0, 'h001, 1'b1);
    // In the SWAP cycle: a write (with last) that must be dropped.
    drive_px(3, 5, 'h777, 1'b1);
    total++; if (bus.frame_cnt !== 8'd2) begin bad++; $display("FAIL swapcyc_cnt got=%0h exp=2", bus.frame_cnt); end
    total++; if (bus.front_sel !== 1'b0) begin bad++; $display("FAIL swapcyc_front got=%0h exp=0", bus.front_sel); end
    total++; if (bus.swap_pulse !== 1'b0) begin bad++; $display("FAIL swapcyc_pulse got=%0h exp=0", bus.swap_pulse); end
    set_rd(3, 5);
    step();
    total++; if (bus.rd_data !== 12'h123) begin bad++; $display("FAIL swapcyc_read got=%0h exp=123", bus.rd_data); end
    drive_px(0, 0, 'h002, 1'b1);
    step();
    total++; if (bus.rd_data !== 12'hABC) begin bad++; $display("FAIL keep_old_read got=%0h exp=abc", bus.rd_data); end
  endtask

  task automatic test_vblank_ignored();
    bus.vblank = 1'b1;
    step();
    bus.vblank = 1'b0;
    step();
    total++; if (bus.frame_cnt !== 8'd3) begin bad++; $display("FAIL vblank_no_swap got=%0h exp=3", bus.frame_cnt); end
  endtask

  task automatic test_reset_abandon();
    drive_px(2, 2, 'h0F0, 1'b0);
    do_reset();
    total++; if (bus.front_sel !== 1'b0) begin bad++; $display("FAIL abandon_front got=%0h exp=0", bus.front_sel); end
    total++; if (bus.frame_cnt !== 8'd0) begin bad++; $display("FAIL abandon_cnt got=%0h exp=0", bus.frame_cnt); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 256; i++) begin
      drive_px(0, 2, i, 1'b1);
      step();
      if (i == 254) begin
        total++; if (bus.frame_cnt !== 8'd255) begin bad++; $display("FAIL wrap_255 got=%0h exp=ff", bus.frame_cnt); end
        total++; if (bus.front_sel !== 1'b1) begin bad++; $display("FAIL wrap_front_odd got=%0h exp=1", bus.front_sel); end
      end
    end
    total++; if (bus.frame_cnt !== 8'd0) begin bad++; $display("FAIL wrap_cnt got=%0h exp=0", bus.frame_cnt); end
    total++; if (bus.front_sel !== 1'b0) begin bad++; $display("FAIL wrap_front got=%0h exp=0", bus.front_sel); end
  endtask

`endif

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_row  = '0;
    bus.wr_col  = '0;
    bus.wr_data = '0;
    bus.wr_last = 1'b0;
    bus.rd_row  = '0;
    bus.rd_col  = '0;
    bus.vblank  = 1'b0;

    test_reset();
    test_handoff();
`ifdef FB_TEAR_FREE_EN
    test_stall();
    test_coincident();
`else
    test_swap_ignores_writes();
    test_vblank_ignored();
`endif
    test_reset_abandon();
    test_wrap();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
